tm_output_collector: RTL

Downstream stage of the configurable data path. It takes the serial stream of scaled output features, one output channel per cycle, and packs Tm consecutive channels into one output-pixel line. Packing uses two ping-pong line buffers, with optional ReLU. Each complete line is handed to the output feature memory writer over a valid/ready handshake, with an auto-incrementing pixel address.

---
 rtl/tm_output_collector.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/tm_output_collector.sv
// tm_output_collector: packs a serial stream of scaled output features
// into Tm-lane lines and hands them to the output memory writer.
//
// Ports:
//   clk, rst           - system clock, synchronous active-high reset
//   cfg_start          - one-cycle tile start pulse (accepted in IDLE)
//   cfg_pixel_count    - lines per tile (0 behaves as 1)
//   cfg_base_addr      - address of the first line
//   cfg_relu           - clamp negative features to zero
//   in_valid/channel/data - serial feature input, one lane per cycle
//   out_valid/ready    - line handshake towards the memory writer
//   out_addr/out_data  - presented line address and packed lanes
//   busy, done         - tile in progress / one-cycle completion pulse
//   err_overflow       - sticky: feature dropped, fill buffer full
//   err_channel        - sticky: feature dropped, lane index >= Tm
module tm_output_collector #(
  parameter int Tm            = 16,
  parameter int FEATURE_WIDTH = 16,
  parameter int ADDR_WIDTH    = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_start,
  input  logic [ADDR_WIDTH-1:0]       cfg_pixel_count,
  input  logic [ADDR_WIDTH-1:0]       cfg_base_addr,
  input  logic                        cfg_relu,
  input  logic                        in_valid,
  input  logic [4:0]                  in_channel,
  input  logic [FEATURE_WIDTH-1:0]    in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic [Tm*FEATURE_WIDTH-1:0] out_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err_overflow,
  output logic                        err_channel
);

  localparam int FW = FEATURE_WIDTH;
  localparam int LW = (Tm > 1) ? $clog2(Tm) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [LW-1:0] LAST_LANE = LW'(Tm - 1);
  localparam logic [5:0]    TM_LIMIT  = 6'(Tm);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [0:0]            state;
  logic [FW-1:0]         lanes [2][Tm];
  logic [1:0]            full;
  logic                  fill_ptr;
  logic                  drain_ptr;
  logic [ADDR_WIDTH-1:0] line_cnt;
  logic [ADDR_WIDTH-1:0] last_line;
  logic                  relu;

  logic                  fire;
  logic                  is_last;
  logic                  ch_ok;
  logic [LW-1:0]         lane_idx;
  logic [FW-1:0]         wval;

  assign out_valid = full[drain_ptr];
  assign fire      = out_valid && out_ready;
  assign is_last   = (line_cnt == last_line);
  assign busy      = (state == RUN);

  assign ch_ok     = ({1'b0, in_channel} < TM_LIMIT);
  assign lane_idx  = in_channel[LW-1:0];
  assign wval      = (relu && in_data[FW-1]) ? '0 : in_data;

  for (genvar i = 0; i < Tm; i++) begin : g_pack
    assign out_data[i*FW +: FW] = lanes[drain_ptr][i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      full         <= '0;
      fill_ptr     <= 1'b0;
      drain_ptr    <= 1'b0;
      line_cnt     <= '0;
      last_line    <= '0;
      relu         <= 1'b0;
      out_addr     <= '0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      err_channel  <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < Tm; i++)
          lanes[b][i] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            state        <= RUN;
            full         <= '0;
            fill_ptr     <= 1'b0;
            drain_ptr    <= 1'b0;
            line_cnt     <= '0;
            last_line    <= (cfg_pixel_count == '0) ?
                            '0 : cfg_pixel_count - ONE;
            relu         <= cfg_relu;
            out_addr     <= cfg_base_addr;
            err_overflow <= 1'b0;
            err_channel  <= 1'b0;
            for (int b = 0; b < 2; b++)
              for (int i = 0; i < Tm; i++)
                lanes[b][i] <= '0;
          end
        end
        RUN: begin
          // Drain: a full drain buffer is never the fill target,
          // so clearing it cannot collide with a lane write.
          if (fire) begin
            full[drain_ptr] <= 1'b0;
            drain_ptr       <= ~drain_ptr;
            out_addr        <= out_addr + ONE;
            line_cnt        <= line_cnt + ONE;
            for (int i = 0; i < Tm; i++)
              lanes[drain_ptr][i] <= '0;
          end
          if (in_valid) begin
            if (!ch_ok) begin
              err_channel <= 1'b1;
            end else if (full[fill_ptr]) begin
              err_overflow <= 1'b1;
            end else begin
              lanes[fill_ptr][lane_idx] <= wval;
              if (lane_idx == LAST_LANE) begin
                full[fill_ptr] <= 1'b1;
                fill_ptr       <= ~fill_ptr;
              end
            end
          end
          // Tile end: drop any surplus line so IDLE shows nothing.
          if (fire && is_last) begin
            state <= IDLE;
            done  <= 1'b1;
            full  <= '0;
            for (int b = 0; b < 2; b++)
              for (int i = 0; i < Tm; i++)
                lanes[b][i] <= '0;
          end
        end
      endcase
    end
  end

endmodule
